zion_basic_circuit_lib_arb_rr_onehot: RTL and testbench
=======================================================

ZION_BASIC_CIRCUIT_LIB_ARB_RR_ONEHOT -- requirements
Module: zion_basic_circuit_lib_arb_rr_onehot

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters; legal values are 2..32.
REQ-002 SHALL have parameter PKT_LOCK, default 1; 1 holds the grant until the iLast beat, 0 re-arbitrates after every beat.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port iReq, input, NUM_REQ, per-requester request; bit i asserted means requester i has data.
REQ-006 SHALL have port iLast, input, 1, last-beat flag of the currently granted source.
REQ-007 SHALL have port iRdy, input, 1, downstream ready.
REQ-008 SHALL have port oGnt, output, NUM_REQ, registered onehot0 grant; drives the select of the downstream onehot mux directly.
REQ-009 SHALL have port oGntIdx, output, $clog2(NUM_REQ), binary index of the granted bit; 0 when there is no grant.
REQ-010 SHALL have port oVld, output, 1, transfer valid toward downstream.

Function
REQ-011 SHALL implement a two-state FSM with states IDLE and BUSY; oVld = (state == BUSY).
REQ-012 SHALL keep a round-robin pointer ptr of width $clog2(NUM_REQ); search order is ptr, ptr+1, ..., wrapping modulo NUM_REQ.
REQ-013 SHALL, in IDLE with |iReq, select the first requesting index in search order and register it into oGnt and oGntIdx; state becomes BUSY on the next edge (latency of 1 cycle).
REQ-014 SHALL remain in IDLE with oGnt = 0 while iReq == 0.
REQ-015 SHALL treat a beat as transferred when oVld && iRdy.
REQ-016 SHALL hold oGnt, oGntIdx and ptr stable in BUSY until a beat ends the grant; the grant ends on a transfer with iLast = 1, or on any transfer when PKT_LOCK = 0.
REQ-017 SHALL, at grant end, set ptr to (oGntIdx + 1) mod NUM_REQ.
REQ-018 SHALL, at grant end, re-arbitrate in the same cycle using the updated pointer and the current iReq, so that the grant switches with no bubble.
REQ-019 SHALL, at grant end with no requester other than the current one asserted and the current requester still asserted, re-grant the same requester.
REQ-020 SHALL, at grant end with iReq == 0, go to IDLE with oGnt = 0 and oGntIdx = 0 on the next edge.
REQ-021 SHALL ignore iReq changes of ungranted requesters while BUSY; they do not preempt the current grant.
REQ-022 SHALL NOT have oGnt depend combinationally on iReq, iLast or iRdy; it is a pure register output.
REQ-023 SHALL, in simulation only, assert $onehot0(oGnt) on every cycle.
REQ-024 SHALL, in simulation only, report an error if the granted iReq bit deasserts while BUSY before its grant ends.
REQ-025 SHALL, in simulation only, report an $error at time 0 if NUM_REQ is outside 2..32.

Reset
REQ-026 SHALL, while rst = 1 and independent of clk, force state = IDLE, ptr = 0, oGnt = 0, oGntIdx = 0 and oVld = 0.
REQ-027 SHALL, on rst asserted mid-packet, drop the grant immediately with no transfer completed; after release, arbitration restarts from ptr = 0.
REQ-028 SHALL allow the first grant no earlier than the first rising clk edge after rst deasserts.

Verification
REQ-029 SHALL cover this scenario (NUM_REQ=4, PKT_LOCK=1): reset, then iReq = 4'b1010 and iRdy = 1 with iLast = 1 on every beat -> oGnt sequence 0010, 1000, 0010, 1000, switching on every cycle with no bubble.
REQ-030 SHALL cover this scenario: iReq = 4'b0011, requester 0 sends a 3-beat packet with iLast on beat 3 and iRdy = 1 -> oGnt = 0001 for exactly 3 cycles, then 0010; requester 1's request does not preempt.
REQ-031 SHALL cover this scenario (backpressure): grant 0100 and iRdy = 0 for 5 cycles while iReq changes -> oGnt, oGntIdx = 2 and ptr stay unchanged; the transfer completes on the first cycle with iRdy = 1.
REQ-032 SHALL cover this scenario: PKT_LOCK = 0, iReq = 4'b1111, iRdy = 1, iLast = 0 -> oGntIdx cycles 0, 1, 2, 3, 0 (wrap-around).
REQ-033 SHALL cover this scenario: rst pulsed asynchronously between clock edges during beat 2 of a packet from requester 3 -> oGnt = 0 and oVld = 0 immediately; after release with iReq = 4'b1001, the first grant is 0001.
REQ-034 SHALL cover this scenario: single request iReq = 4'b0100, one-beat packets, then iReq = 0 -> grant 0100 is repeated each cycle; after the last beat, IDLE with oGnt = 0 and oGntIdx = 0.

Source files
------------

// File: rtl/zion_basic_circuit_lib_arb_rr_onehot.sv
// Round-robin arbiter with registered onehot grant.
// A grant is issued from IDLE one cycle after a request appears, then held
// (optionally for a whole packet) until the granted beat completes. At grant
// end the pointer moves past the winner and the next grant is chosen in the
// same cycle, so back-to-back packets see no bubble.

module zion_basic_circuit_lib_arb_rr_onehot #(
  parameter int NUM_REQ  = 4,
  parameter int PKT_LOCK = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         iReq,
  input  logic                       iLast,
  input  logic                       iRdy,
  output logic [NUM_REQ-1:0]         oGnt,
  output logic [$clog2(NUM_REQ)-1:0] oGntIdx,
  output logic                       oVld
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [IW-1:0]        ptr_r;
  logic [IW-1:0]        ptr_nxt_s;
  logic [IW-1:0]        gnt_idx_r;
  logic [IW-1:0]        gnt_idx_nxt_s;
  logic [NUM_REQ-1:0]   gnt_r;
  logic [NUM_REQ-1:0]   gnt_nxt_s;
  logic                 grant_end_s;
  logic [IW-1:0]        end_ptr_s;
  logic [IW:0]          idle_pick_s;
  logic [IW:0]          end_pick_s;

  // Search req starting at base and wrapping; returns {hit, index}.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [IW-1:0]      base);
    logic          hit;
    logic [IW-1:0] idx;
    logic [IW-1:0] cand;
    int            sum;
    hit = 1'b0;
    idx = {IW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      sum  = int'(base) + k;
      cand = (sum >= NUM_REQ) ? IW'(sum - NUM_REQ) : IW'(sum);
      idx  = (!hit && req[cand]) ? cand : idx;
      hit  = hit | req[cand];
    end
    return {hit, idx};
  endfunction

  // Binary index to onehot select vector.
  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IW-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Grant end condition and the pointer / candidate for the next grant.
  always_comb begin
    grant_end_s = (state_r == BUSY) && iRdy && (iLast || (PKT_LOCK == 0));
    end_ptr_s   = (gnt_idx_r == IW'(NUM_REQ - 1)) ? {IW{1'b0}} : (gnt_idx_r + {{(IW-1){1'b0}}, 1'b1});
    idle_pick_s = rr_pick(iReq, ptr_r);
    end_pick_s  = rr_pick(iReq, end_ptr_s);
  end

  // Next-state logic: start a grant from IDLE, hold in BUSY, re-arbitrate at grant end.
  always_comb begin
    state_nxt_s   = state_r;
    ptr_nxt_s     = ptr_r;
    gnt_nxt_s     = gnt_r;
    gnt_idx_nxt_s = gnt_idx_r;
    case (state_r)
      IDLE: begin
        if (idle_pick_s[IW]) begin
          state_nxt_s   = BUSY;
          gnt_idx_nxt_s = idle_pick_s[IW-1:0];
          gnt_nxt_s     = to_onehot(idle_pick_s[IW-1:0]);
        end else begin
          state_nxt_s   = IDLE;
          gnt_idx_nxt_s = {IW{1'b0}};
          gnt_nxt_s     = {NUM_REQ{1'b0}};
        end
      end
      BUSY: begin
        if (grant_end_s) begin
          ptr_nxt_s = end_ptr_s;
          if (end_pick_s[IW]) begin
            state_nxt_s   = BUSY;
            gnt_idx_nxt_s = end_pick_s[IW-1:0];
            gnt_nxt_s     = to_onehot(end_pick_s[IW-1:0]);
          end else begin
            state_nxt_s   = IDLE;
            gnt_idx_nxt_s = {IW{1'b0}};
            gnt_nxt_s     = {NUM_REQ{1'b0}};
          end
        end else begin
          state_nxt_s   = BUSY;
          gnt_idx_nxt_s = gnt_idx_r;
          gnt_nxt_s     = gnt_r;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        ptr_nxt_s     = {IW{1'b0}};
        gnt_idx_nxt_s = {IW{1'b0}};
        gnt_nxt_s     = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // State, pointer and grant registers; rst clears them without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= {IW{1'b0}};
      gnt_idx_r <= {IW{1'b0}};
      gnt_r     <= {NUM_REQ{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      ptr_r     <= ptr_nxt_s;
      gnt_idx_r <= gnt_idx_nxt_s;
      gnt_r     <= gnt_nxt_s;
    end
  end

  assign oGnt    = gnt_r;
  assign oGntIdx = gnt_idx_r;
  assign oVld    = (state_r == BUSY);

  zion_basic_circuit_lib_arb_rr_onehot_chk #(
    .NUM_REQ (NUM_REQ)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .req       (iReq),
    .gnt       (gnt_r),
    .gnt_idx   (gnt_idx_r),
    .busy      (state_r == BUSY),
    .grant_end (grant_end_s)
  );

endmodule

// Simulation-only property checks for the arbiter.
module zion_basic_circuit_lib_arb_rr_onehot_chk #(
  parameter int NUM_REQ = 4
) (
  input logic                       clk,
  input logic                       rst,
  input logic [NUM_REQ-1:0]         req,
  input logic [NUM_REQ-1:0]         gnt,
  input logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  input logic                       busy,
  input logic                       grant_end
);

  if ((NUM_REQ < 2) || (NUM_REQ > 32)) begin : g_bad_num_req
    $error("NUM_REQ=%0d outside legal range 2..32", NUM_REQ);
  end

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
    else $error("grant vector is not onehot0: %b", gnt);

  a_req_held : assert property (@(posedge clk) disable iff (rst) (busy && !grant_end) |-> req[gnt_idx])
    else $error("granted requester %0d dropped its request before grant end", gnt_idx);

endmodule

// File: tb/tb_zion_basic_circuit_lib_arb_rr_onehot.sv
// Bench for the round-robin onehot arbiter: directed vector table, hand-built
// reset / wrap sequences, then randomized traffic against a reference model.

module tb_zion_basic_circuit_lib_arb_rr_onehot;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req0;
  logic       last, rdy, last0, rdy0;
  logic [3:0] gnt, gnt0;
  logic [1:0] idx, idx0;
  logic       vld, vld0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  zion_basic_circuit_lib_arb_rr_onehot #(.NUM_REQ(4), .PKT_LOCK(1)) dut (
    .clk(clk), .rst(rst), .iReq(req), .iLast(last), .iRdy(rdy),
    .oGnt(gnt), .oGntIdx(idx), .oVld(vld)
  );

  zion_basic_circuit_lib_arb_rr_onehot #(.NUM_REQ(4), .PKT_LOCK(0)) dut0 (
    .clk(clk), .rst(rst), .iReq(req0), .iLast(last0), .iRdy(rdy0),
    .oGnt(gnt0), .oGntIdx(idx0), .oVld(vld0)
  );

  typedef struct {
    logic [3:0] req;
    logic       last;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
  } vec_t;

  // Reference arbiter state: who holds the grant and where the search starts.
  typedef struct {
    bit busy;
    int ptr;
    int gidx;
  } mdl_t;

  vec_t tbl[$];
  mdl_t m, m0;
  mdl_t mdl_reset = '{busy: 1'b0, ptr: 0, gidx: 0};

  function automatic int first_req(logic [3:0] r, int start);
    for (int k = 0; k < 4; k++) begin
      int p = (start + k) % 4;
      if (r[p[1:0]]) return p;
    end
    return -1;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, logic [3:0] r, logic l, logic y, bit lock);
    mdl_t n = s;
    int   w;
    if (!s.busy) begin
      w = first_req(r, s.ptr);
      if (w >= 0) begin
        n.busy = 1'b1;
        n.gidx = w;
      end
    end else if (y && (l || !lock)) begin
      n.ptr = (s.gidx + 1) % 4;
      w = first_req(r, n.ptr);
      if (w >= 0) n.gidx = w;
      else begin
        n.busy = 1'b0;
        n.gidx = 0;
      end
    end
    return n;
  endfunction

  task automatic chk_out(string tag, logic [3:0] g, logic [1:0] i, logic v,
                         logic [3:0] eg, logic [1:0] ei, logic ev);
    n_chk++;
    if (g !== eg) begin
      n_err++;
      $display("FAIL %s.gnt: got %b expected %b (t=%0t)", tag, g, eg, $time);
    end
    n_chk++;
    if (i !== ei) begin
      n_err++;
      $display("FAIL %s.idx: got %0d expected %0d (t=%0t)", tag, i, ei, $time);
    end
    n_chk++;
    if (v !== ev) begin
      n_err++;
      $display("FAIL %s.vld: got %b expected %b (t=%0t)", tag, v, ev, $time);
    end
  endtask

  task automatic chk_mdl(string tag, logic [3:0] g, logic [1:0] i, logic v, mdl_t s);
    logic [3:0] eg;
    eg = s.busy ? 4'(4'b0001 << s.gidx) : 4'b0000;
    chk_out(tag, g, i, v, eg, 2'(s.gidx), s.busy);
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000; last = 1'b0; rdy = 1'b0;
    req0 = 4'b0000; last0 = 1'b0; rdy0 = 1'b0;

    // alternating pair, one-beat packets: grant flips every cycle
    tbl.push_back('{4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1});
    tbl.push_back('{4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1});
    tbl.push_back('{4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1});
    tbl.push_back('{4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1});
    // lone requester re-granted each beat, then drains to IDLE
    tbl.push_back('{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1});
    tbl.push_back('{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1});
    tbl.push_back('{4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0});
    // ptr=3: requester 0 wins, 3-beat packet not preempted by requester 1
    tbl.push_back('{4'b0011, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1});
    tbl.push_back('{4'b0011, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1});
    tbl.push_back('{4'b0011, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1});
    tbl.push_back('{4'b0011, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1});
    // move grant to requester 2, then 5 cycles of backpressure with churn
    tbl.push_back('{4'b0110, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1});
    tbl.push_back('{4'b1111, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1});
    tbl.push_back('{4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1});
    tbl.push_back('{4'b0101, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1});
    tbl.push_back('{4'b1110, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1});
    tbl.push_back('{4'b0111, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1});
    // first ready cycle completes; ptr was 2 so search from 3 picks 3 over 0
    tbl.push_back('{4'b1101, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1});
    tbl.push_back('{4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", gnt, idx, vld, 4'b0000, 2'd0, 1'b0);
    chk_out("reset_nolock", gnt0, idx0, vld0, 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      req  = tbl[i].req;
      last = tbl[i].last;
      rdy  = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk_out($sformatf("vec%0d", i), gnt, idx, vld, tbl[i].gnt, tbl[i].idx, tbl[i].vld);
    end

    // async reset during beat 2 of a packet from requester 3
    req = 4'b1000; last = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
    chk_out("rst_mid_beat1", gnt, idx, vld, 4'b1000, 2'd3, 1'b1);
    @(posedge clk); #1;
    chk_out("rst_mid_beat2", gnt, idx, vld, 4'b1000, 2'd3, 1'b1);
    #3; rst = 1'b1; #1;
    chk_out("rst_mid_drop", gnt, idx, vld, 4'b0000, 2'd0, 1'b0);
    req = 4'b1001;
    #2; rst = 1'b0; #1;
    chk_out("rst_release_nogrant", gnt, idx, vld, 4'b0000, 2'd0, 1'b0);
    @(posedge clk); #1;
    chk_out("rst_first_grant", gnt, idx, vld, 4'b0001, 2'd0, 1'b1);

    // no packet lock: every beat re-arbitrates and the index wraps
    req = 4'b0000; last = 1'b1; rdy = 1'b1;
    req0 = 4'b1111; last0 = 1'b0; rdy0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk_out($sformatf("nolock_wrap%0d", k), gnt0, idx0, vld0,
              4'(4'b0001 << (k % 4)), 2'(k % 4), 1'b1);
    end
    chk_out("drain_idle", gnt, idx, vld, 4'b0000, 2'd0, 1'b0);

    // randomized traffic on both instances against the reference model
    rst = 1'b1; req0 = 4'b0000; #2; rst = 1'b0;
    m = mdl_reset;
    m0 = mdl_reset;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 701) == 700) begin
        rst = 1'b1; #1;
        chk_out("rand_rst", gnt, idx, vld, 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        m = mdl_reset;
        m0 = mdl_reset;
      end
      rdy  = ($urandom_range(0, 3) != 0);
      last = ($urandom_range(0, 2) == 0);
      req  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      if (m.busy && !(rdy && last)) req[2'(m.gidx)] = 1'b1;
      rdy0  = ($urandom_range(0, 2) != 0);
      last0 = ($urandom_range(0, 1) == 0);
      req0  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      if (m0.busy && !rdy0) req0[2'(m0.gidx)] = 1'b1;
      @(posedge clk);
      m  = mdl_step(m, req, last, rdy, 1'b1);
      m0 = mdl_step(m0, req0, last0, rdy0, 1'b0);
      #1;
      chk_mdl($sformatf("rand%0d", c), gnt, idx, vld, m);
      chk_mdl($sformatf("rand_nolock%0d", c), gnt0, idx0, vld0, m0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
